// File: rtl/pll_rcfg_pkg.sv
// Shared constants, FSM state encoding and the two-preset register ROM for the PLL reconfig sequencer.
// Preset 0 is PAL (35.468944 / 70.937888 MHz), preset 1 is NTSC.
package pll_rcfg_pkg;

    localparam logic [5:0] ADDR_MODE   = 6'd0;
    localparam logic [5:0] ADDR_STATUS = 6'd1;
    localparam logic [5:0] ADDR_START  = 6'd2;
    localparam logic [5:0] ADDR_N      = 6'd3;
    localparam logic [5:0] ADDR_M      = 6'd4;
    localparam logic [5:0] ADDR_C      = 6'd5;
    localparam logic [5:0] ADDR_K      = 6'd7;

    localparam int ROM_WRITES = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE,
        ST_WRITE,
        ST_START,
        ST_SETTLE,
        ST_LOCK,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } rcfg_entry_t;

    // Both C writes go to the same address; the counter select lives in the data word.
    localparam rcfg_entry_t PRESET_ROM [2*ROM_WRITES] = '{
        '{ADDR_N, 32'h0001_0000},
        '{ADDR_M, 32'h0002_0504},
        '{ADDR_C, 32'h0000_0707},
        '{ADDR_C, 32'h0006_0403},
        '{ADDR_K, 32'hEE69_F5BD},
        '{ADDR_N, 32'h0001_0000},
        '{ADDR_M, 32'h0002_0606},
        '{ADDR_C, 32'h0000_0808},
        '{ADDR_C, 32'h0006_0404},
        '{ADDR_K, 32'h1C71_C71C}
    };

    function automatic rcfg_entry_t rom_entry(input logic p, input logic [2:0] idx);
        logic [3:0] i;
        i = {1'b0, idx} + (p ? 4'(ROM_WRITES) : 4'd0);
        return PRESET_ROM[i];
    endfunction

endpackage

// File: rtl/pll_rcfg_avmm_wr.sv
// Single Avalon-MM write engine: start latches addr/data, ack is the accepting edge (mgmt_write & ~waitrequest).
// Holds the bus stable while stalled; write drops for one cycle after ack so back-to-back writes are gapped.
module pll_rcfg_avmm_wr
    import pll_rcfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  addr,
    input  logic [31:0] data,
    output logic        ack,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest
);

    assign ack = mgmt_write && !mgmt_waitrequest;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
        end else if (ack) begin
            mgmt_write <= 1'b0;
        end else if (start && !mgmt_write) begin
            mgmt_write     <= 1'b1;
            mgmt_address   <= addr;
            mgmt_writedata <= data;
        end
    end

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL preset switch sequencer: mode, ROM, start writes, settle, then lock wait with timeout; done pulses per sequence.
// Optional PLL_RCFG_AUTORETRY_EN: first lock timeout of a request silently restarts from MODE once.
module pll_reconfig_seq
    import pll_rcfg_pkg::*;
#(
    parameter int NUM_WRITES     = 5,
    parameter int SETTLE_CYCLES  = 16,
    parameter int LOCK_TIMEOUT   = 1048576,
    parameter bit DEFAULT_PRESET = 1'b0
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        preset,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cur_preset,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest
);

    localparam int CW = $clog2((LOCK_TIMEOUT > SETTLE_CYCLES ? LOCK_TIMEOUT : SETTLE_CYCLES) + 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      idx, idx_nxt;
    logic            run_preset, run_preset_nxt;
    logic            pend, pend_nxt;
    logic            pend_preset, pend_preset_nxt;
    logic            err_nxt, cur_nxt;
    logic            lock_s1, lock_s2;
    logic            wr_start, wr_ack;
    rcfg_entry_t     wr_entry;
`ifdef PLL_RCFG_AUTORETRY_EN
    logic            retried, retried_nxt;
`endif

    assign busy = (state != ST_IDLE) && (state != ST_FIN);
    assign done = (state == ST_FIN);

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            run_preset  <= 1'b0;
            pend        <= 1'b0;
            pend_preset <= 1'b0;
            err         <= 1'b0;
            cur_preset  <= DEFAULT_PRESET;
            lock_s1     <= 1'b0;
            lock_s2     <= 1'b0;
`ifdef PLL_RCFG_AUTORETRY_EN
            retried     <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            run_preset  <= run_preset_nxt;
            pend        <= pend_nxt;
            pend_preset <= pend_preset_nxt;
            err         <= err_nxt;
            cur_preset  <= cur_nxt;
            lock_s1     <= pll_locked;
            lock_s2     <= lock_s1;
`ifdef PLL_RCFG_AUTORETRY_EN
            retried     <= retried_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = '0;
        idx_nxt         = idx;
        run_preset_nxt  = run_preset;
        pend_nxt        = pend;
        pend_preset_nxt = pend_preset;
        err_nxt         = err;
        cur_nxt         = cur_preset;
        wr_start        = 1'b0;
        wr_entry        = '{addr: ADDR_MODE, data: 32'h0};
`ifdef PLL_RCFG_AUTORETRY_EN
        retried_nxt     = retried;
`endif

        // Requests arriving while a sequence runs park in a one-deep slot; the latest one wins.
        if (state != ST_IDLE && req) begin
            pend_nxt        = 1'b1;
            pend_preset_nxt = preset;
        end

        case (state)
            ST_IDLE: begin
                if (req || pend) begin
                    state_nxt      = ST_MODE;
                    run_preset_nxt = req ? preset : pend_preset;
                    pend_nxt       = 1'b0;
                    err_nxt        = 1'b0;
`ifdef PLL_RCFG_AUTORETRY_EN
                    retried_nxt    = 1'b0;
`endif
                end
            end
            ST_MODE: begin
                wr_start = !mgmt_write;
                idx_nxt  = '0;
                if (wr_ack) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                wr_entry = rom_entry(run_preset, idx);
                wr_start = !mgmt_write;
                if (wr_ack) begin
                    if (idx == 3'(NUM_WRITES - 1)) state_nxt = ST_START;
                    else                           idx_nxt   = idx + 3'd1;
                end
            end
            ST_START: begin
                // The core stalls this write for the whole reconfiguration.
                wr_entry = '{addr: ADDR_START, data: 32'h0};
                wr_start = !mgmt_write;
                if (wr_ack) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) state_nxt = ST_LOCK;
                else                               cnt_nxt   = cnt + CW'(1);
            end
            ST_LOCK: begin
                // Lock is checked before the limit so a lock on the final cycle still succeeds.
                if (lock_s2) begin
                    cur_nxt   = run_preset;
                    err_nxt   = 1'b0;
                    state_nxt = ST_FIN;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
`ifdef PLL_RCFG_AUTORETRY_EN
                    if (!retried) begin
                        retried_nxt = 1'b1;
                        state_nxt   = ST_MODE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_FIN;
                    end
`else
                    err_nxt   = 1'b1;
                    state_nxt = ST_FIN;
`endif
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    pll_rcfg_avmm_wr u_wr (
        .clk              (refclk),
        .rst_n            (rst_n),
        .start            (wr_start),
        .addr             (wr_entry.addr),
        .data             (wr_entry.data),
        .ack              (wr_ack),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest)
    );

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: table of full sequences plus pending-request and mid-sequence reset cases.
module tb_pll_reconfig_seq;

    typedef logic [37:0] wr_t;

    typedef struct {
        bit p;
        int lock_at;     // cycles after START acceptance to raise pll_locked; -1 = never
        int stall;       // waitrequest cycles on the M write
        int exp_writes;
        bit exp_err;
        bit exp_cur;
    } run_t;

    logic        refclk = 1'b0;
    logic        rst_n, req, preset, pll_locked, mgmt_waitrequest;
    logic        busy, done, err, cur_preset, mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int start_cyc = -1;
    int low_run = 0;
    bit prev_wr = 0;
    bit have_prev = 0;
    int stall_cnt, m_seen, m_bad;
    logic [37:0] m_ref;
    wr_t log_q[$];
    int  gap_q[$];
    wr_t exp_seq [2][7];
    run_t runs [8];

    pll_reconfig_seq #(.LOCK_TIMEOUT(64)) dut (
        .refclk           (refclk),
        .rst_n            (rst_n),
        .req              (req),
        .preset           (preset),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .cur_preset       (cur_preset),
        .pll_locked       (pll_locked),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc++;

    // Bus monitor: logs accepted writes, idle gaps between writes and done pulses.
    always @(negedge refclk) begin
        if (mgmt_write === 1'b1) begin
            if (!prev_wr && have_prev) gap_q.push_back(low_run);
            low_run = 0;
            if (mgmt_waitrequest === 1'b0) begin
                log_q.push_back({mgmt_address, mgmt_writedata});
                have_prev = 1;
                if (mgmt_address == 6'd2) start_cyc = cyc;
            end
        end else begin
            low_run++;
        end
        prev_wr = (mgmt_write === 1'b1);
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int lock_at, input int stall);
        @(posedge refclk);
        #1;
        if (lock_at >= 0 && start_cyc >= 0 && cyc == start_cyc + lock_at) pll_locked = 1'b1;
        mgmt_waitrequest = 1'b0;
        if (mgmt_write === 1'b1 && mgmt_address == 6'd4) begin
            if (m_seen == 0) m_ref = {mgmt_address, mgmt_writedata};
            else if ({mgmt_address, mgmt_writedata} !== m_ref) m_bad++;
            m_seen++;
            if (stall_cnt < stall) begin
                mgmt_waitrequest = 1'b1;
                stall_cnt++;
            end
        end
        // A retry rewrites M; allow it to be stalled again.
        if (mgmt_write !== 1'b1 && mgmt_address == 6'd2) stall_cnt = 0;
    endtask

    task automatic clear_mon();
        log_q.delete();
        gap_q.delete();
        have_prev = 0;
        start_cyc = -1;
        m_seen = 0;
        m_bad = 0;
        stall_cnt = 0;
    endtask

    task automatic run_row(input int k, input run_t r);
        int dc0;
        bit got;
        int gap_bad;
        pll_locked = 1'b0;
        clear_mon();
        dc0 = done_cnt;
        req = 1'b1;
        preset = r.p;
        step(r.lock_at, r.stall);
        req = 1'b0;
        chk($sformatf("row%0d busy_after_accept", k), busy, 1);
        chk($sformatf("row%0d err_cleared", k), err, 0);
        got = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            step(r.lock_at, r.stall);
            if (done_cnt != dc0) got = 1;
        end
        chk($sformatf("row%0d done_seen", k), got, 1);
        repeat (5) step(r.lock_at, r.stall);
        chk($sformatf("row%0d done_count", k), done_cnt - dc0, 1);
        chk($sformatf("row%0d err", k), err, r.exp_err);
        chk($sformatf("row%0d cur_preset", k), cur_preset, r.exp_cur);
        chk($sformatf("row%0d busy_end", k), busy, 0);
        chk($sformatf("row%0d write_count", k), log_q.size(), r.exp_writes);
        for (int i = 0; i < log_q.size() && i < r.exp_writes; i++)
            chk($sformatf("row%0d write%0d", k, i), log_q[i], exp_seq[r.p][i % 7]);
        gap_bad = 0;
        for (int i = 1; i < log_q.size(); i++)
            if (i % 7 != 0 && (gap_q.size() < i || gap_q[i-1] != 1)) gap_bad++;
        chk($sformatf("row%0d bad_gaps", k), gap_bad, 0);
        chk($sformatf("row%0d m_cycles", k), m_seen, (r.stall + 1) * (r.exp_writes / 7));
        chk($sformatf("row%0d m_unstable", k), m_bad, 0);
    endtask

    initial begin
        int dc0;
        bit found;

        exp_seq[0] = '{38'({6'd0, 32'h0}), 38'({6'd3, 32'h0001_0000}), 38'({6'd4, 32'h0002_0504}),
                       38'({6'd5, 32'h0000_0707}), 38'({6'd5, 32'h0006_0403}), 38'({6'd7, 32'hEE69_F5BD}),
                       38'({6'd2, 32'h0})};
        exp_seq[1] = '{38'({6'd0, 32'h0}), 38'({6'd3, 32'h0001_0000}), 38'({6'd4, 32'h0002_0606}),
                       38'({6'd5, 32'h0000_0808}), 38'({6'd5, 32'h0006_0404}), 38'({6'd7, 32'h1C71_C71C}),
                       38'({6'd2, 32'h0})};

        runs[0] = '{p: 0, lock_at: 10, stall: 0, exp_writes: 7, exp_err: 0, exp_cur: 0};
        runs[1] = '{p: 1, lock_at: 10, stall: 0, exp_writes: 7, exp_err: 0, exp_cur: 1};
        runs[2] = '{p: 1, lock_at: 10, stall: 0, exp_writes: 7, exp_err: 0, exp_cur: 1};
        runs[3] = '{p: 0, lock_at: 10, stall: 7, exp_writes: 7, exp_err: 0, exp_cur: 0};
        runs[4] = '{p: 1, lock_at: 78, stall: 0, exp_writes: 7, exp_err: 0, exp_cur: 1};
`ifdef PLL_RCFG_AUTORETRY_EN
        runs[5] = '{p: 0, lock_at: 79, stall: 0, exp_writes: 14, exp_err: 0, exp_cur: 0};
        runs[6] = '{p: 1, lock_at: -1, stall: 0, exp_writes: 14, exp_err: 1, exp_cur: 0};
`else
        runs[5] = '{p: 0, lock_at: 79, stall: 0, exp_writes: 7, exp_err: 1, exp_cur: 1};
        runs[6] = '{p: 0, lock_at: -1, stall: 0, exp_writes: 7, exp_err: 1, exp_cur: 1};
`endif
        runs[7] = '{p: 1, lock_at: 10, stall: 0, exp_writes: 7, exp_err: 0, exp_cur: 1};

        rst_n = 1'b0;
        req = 1'b0;
        preset = 1'b0;
        pll_locked = 1'b0;
        mgmt_waitrequest = 1'b0;
        clear_mon();
        repeat (3) @(posedge refclk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst mgmt_write", mgmt_write, 0);
        chk("rst mgmt_address", mgmt_address, 0);
        chk("rst mgmt_writedata", mgmt_writedata, 0);
        chk("rst cur_preset", cur_preset, 0);
        rst_n = 1'b1;
        repeat (2) step(-1, 0);

        for (int k = 0; k < 8; k++) run_row(k, runs[k]);

        // Reset asserted while write entry 2 of preset 0 is on the bus (cur_preset is 1 here).
        pll_locked = 1'b0;
        clear_mon();
        dc0 = done_cnt;
        req = 1'b1;
        preset = 1'b0;
        step(-1, 0);
        req = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(-1, 0);
            if (mgmt_write === 1'b1 && mgmt_address == 6'd5 && mgmt_writedata == 32'h0000_0707) found = 1;
        end
        chk("midrst entry2_seen", found, 1);
        mgmt_waitrequest = 1'b1;
        rst_n = 1'b0;
        @(posedge refclk);
        #1;
        chk("midrst mgmt_write", mgmt_write, 0);
        chk("midrst busy", busy, 0);
        chk("midrst cur_preset", cur_preset, 0);
        chk("midrst err", err, 0);
        rst_n = 1'b1;
        repeat (50) step(-1, 0);
        chk("midrst no_done", done_cnt - dc0, 0);
        chk("midrst idle", busy, 0);

        // Two requests while busy: only the last (preset 0) runs afterwards.
        pll_locked = 1'b0;
        clear_mon();
        dc0 = done_cnt;
        req = 1'b1;
        preset = 1'b1;
        step(10, 0);
        req = 1'b0;
        repeat (3) step(10, 0);
        req = 1'b1;
        preset = 1'b1;
        step(10, 0);
        req = 1'b0;
        repeat (15) step(10, 0);
        req = 1'b1;
        preset = 1'b0;
        step(10, 0);
        req = 1'b0;
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(10, 0);
            if (done_cnt != dc0) found = 1;
        end
        chk("pend first_done", found, 1);
        chk("pend first_cur", cur_preset, 1);
        pll_locked = 1'b0;
        clear_mon();
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(10, 0);
            if (done_cnt - dc0 >= 2) found = 1;
        end
        chk("pend second_done", found, 1);
        repeat (150) step(10, 0);
        chk("pend done_total", done_cnt - dc0, 2);
        chk("pend write_count", log_q.size(), 7);
        for (int i = 0; i < log_q.size() && i < 7; i++)
            chk($sformatf("pend write%0d", i), log_q[i], exp_seq[0][i]);
        chk("pend cur_preset", cur_preset, 0);
        chk("pend err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Management-side sequencer for the Cyclone V reconfigurable video/system PLL.
- On request, switches the PLL between two stored clock presets: preset 0 = PAL (35.468944 / 70.937888 MHz), preset 1 = NTSC.
- Drives the Avalon-MM port of the PLL reconfiguration core through a fixed register-write sequence, then waits for the PLL to relock.
- Sits between the core's video-standard selection logic and the PLL reconfig IP.

Parameters:
- NUM_WRITES, 5, counter/fraction writes per preset (excludes the mode and start writes).
- SETTLE_CYCLES, 16, cycles to wait after the start write before lock is sampled.
- LOCK_TIMEOUT, 1048576, maximum cycles to wait for lock after settle.
- DEFAULT_PRESET, 0, value of cur_preset after reset; matches the power-up PLL configuration.

Ports:
- refclk  in  1  management clock (50 MHz reference).
- rst_n  in  1  reset; synchronous, active-low.
- req  in  1  reconfiguration request (level-sampled).
- preset  in  1  requested preset; sampled with req.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at the end of every sequence, pass or fail.
- err  out  1  lock timeout; sticky until the next accepted request.
- cur_preset  out  1  last successfully applied preset.
- pll_locked  in  1  PLL locked; asynchronous, synchronised internally by 2 flip-flops.
- mgmt_address  out  6  reconfig register address.
- mgmt_write  out  1  write strobe.
- mgmt_writedata  out  32  write data.
- mgmt_waitrequest  in  1  reconfig core stall.

Behaviour:
- Reset values: busy=0, done=0, err=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, cur_preset=DEFAULT_PRESET, pending=0, FSM=IDLE.
- rst_n low mid-transaction: mgmt_write drops at that edge; the transaction is abandoned with no completion.
- Request acceptance:
  - In IDLE, req=1 latches preset and enters MODE; busy rises the next cycle.
  - req while busy sets a single-depth pending flag plus its preset; a later req overwrites the pending preset (last wins).
  - On return to IDLE with pending=1, the pending request starts the next cycle and pending clears.
  - A request equal to cur_preset is still executed.
- Avalon write rule:
  - mgmt_write, mgmt_address and mgmt_writedata are held stable until a rising edge with mgmt_waitrequest=0.
  - mgmt_write is then low for exactly one cycle before the next write.
- FSM states:
  - IDLE
  - MODE: write addr 0 data 0 (waitrequest mode).
  - WRITE: write entries 0..NUM_WRITES-1 of the preset ROM in index order; entry index counter.
  - START: write addr 2 data 0. The core holds waitrequest high during reconfiguration; completion is the waitrequest-low edge.
  - SETTLE: count SETTLE_CYCLES.
  - LOCK: wait for synchronised locked=1, up to LOCK_TIMEOUT cycles.
  - FIN
- LOCK outcome:
  - Lock seen: cur_preset<=preset, err=0.
  - Counter reaches LOCK_TIMEOUT: err=1, cur_preset unchanged.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Timeout boundary: lock asserting in the same cycle the counter hits LOCK_TIMEOUT counts as success.
- Latency for an unstalled sequence: (NUM_WRITES+2)×2 write cycles + SETTLE_CYCLES + lock time + 1.

Optional Feature:
- Macro: PLL_RCFG_AUTORETRY_EN.
- Defined: the first lock timeout of a request restarts the sequence from MODE once, without a done pulse. The second timeout sets err and pulses done. The retry flag clears on each accepted request.
- Undefined: the first timeout sets err and pulses done.

Decomposition:
- Shared package pll_rcfg_pkg holds:
  - Register address constants: MODE=0, STATUS=1, START=2, N=3, M=4, C=5, K=7.
  - FSM state enum.
  - Entry typedef: 6-bit address + 32-bit data.
  - Preset ROM constant, 2×NUM_WRITES entries. PAL entries: N=0x00010000, M=0x00020504, C0=0x00000707, C1=0x00060403, K=0xEE69F5BD.
- One sub-module, pll_rcfg_avmm_wr: the single-write Avalon handshake engine (start/ack, stall hold, one-cycle gap). The FSM lives in the top.

Test Plan:
- Reset, then req=1 preset=0 with waitrequest always 0 and locked rising 10 cycles after START:
  - write sequence is (0,0),(3,0x00010000),(4,0x00020504),(5,0x00000707),(5,0x00060403),(7,0xEE69F5BD),(2,0);
  - one idle cycle between writes;
  - done pulses once, err=0, cur_preset=0.
- Waitrequest held high 7 cycles on the M write: address/data stable for all 8 cycles, no duplicate write, sequence completes.
- req preset=1 mid-sequence, then req preset=0 before FIN: after the first done, exactly one further sequence runs with preset 0.
- locked held 0, LOCK_TIMEOUT=64:
  - without the macro, done at timeout with err=1 and cur_preset unchanged;
  - with PLL_RCFG_AUTORETRY_EN, two full write sequences, then err=1.
- rst_n low during WRITE entry 2: mgmt_write=0 on the next edge, busy=0, cur_preset=DEFAULT_PRESET, and no done pulse afterward.
- Lock asserted exactly at the timeout cycle: err=0 and cur_preset updated.
